// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//
// Parametrised single-clock FIFO for board-level and fabric producers and
// consumers. It can take its write and read requests either as per-cycle
// strobes or as slow level enables, which are synchronised and turned into
// one pulse per rising edge. It offers a standard registered read or a
// first-word-fall-through read. It reports a fill count, almost-full and
// almost-empty thresholds, and sticky overflow and underflow errors.
//
// Parameters
//   DATA_W     data word width in bits
//   ADDR_W     log2 of the depth (DEPTH = 2**ADDR_W), 2..12
//   EDGE_MODE  1: wr_en/rd_en are synchronised and rising-edge detected
//              0: wr_en/rd_en are used directly as per-cycle strobes
//   FWFT       0: standard registered read, 1: first-word-fall-through
//   AF_THRESH  almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   wr_en         write request
//   wr_data       write data, sampled when the internal push strobe is high
//   rd_en         read request / pop
//   err_clr       clears overflow and underflow
//   rd_data       read data (registered)
//   rd_valid      FWFT=0: one-cycle pulse for new rd_data
//                 FWFT=1: a head word is present on rd_data
//   full, empty   FIFO holds DEPTH / 0 words
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         number of stored words, 0..DEPTH
//   overflow      sticky: push attempted while full
//   underflow     sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 9,
  parameter int EDGE_MODE = 1,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = (2 ** ADDR_W) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W + 1)'(AE_THRESH);

  // ---------------------------------------------------------------------------
  // Request conditioning: push/pop are the internal one-cycle strobes.
  // ---------------------------------------------------------------------------
  logic push;
  logic pop;

  if (EDGE_MODE != 0) begin : g_edge
    logic [1:0] wr_sync_q;
    logic [1:0] rd_sync_q;
    logic       wr_prev_q;
    logic       rd_prev_q;

    // Two-flop synchroniser followed by a delayed copy for edge detection.
    // Everything resets to 0, so an enable held high through reset still
    // produces exactly one strobe after release.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_sync_q <= '0;
        rd_sync_q <= '0;
        wr_prev_q <= 1'b0;
        rd_prev_q <= 1'b0;
      end else begin
        wr_sync_q <= {wr_sync_q[0], wr_en};
        rd_sync_q <= {rd_sync_q[0], rd_en};
        wr_prev_q <= wr_sync_q[1];
        rd_prev_q <= rd_sync_q[1];
      end
    end

    assign push = wr_sync_q[1] & ~wr_prev_q;
    assign pop  = rd_sync_q[1] & ~rd_prev_q;
  end else begin : g_strobe
    assign push = wr_en;
    assign pop  = rd_en;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              wr_ok;
  logic              rd_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_addr_d;

  // Accepts use the registered flags, so a rejected request never moves a
  // pointer or touches the memory.
  assign wr_ok     = push & ~full_q;
  assign rd_ok     = pop & ~empty_q;
  assign wr_addr   = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr   = rd_ptr_q[ADDR_W-1:0];
  assign rd_addr_d = rd_ptr_d[ADDR_W-1:0];

  // Pointers carry one extra wrap bit: equal addresses with differing wrap
  // bits means full, and the plain difference is the fill count.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;

    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (count_d == '0);
    full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
              (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    af_d    = (count_d >= AF_LVL);
    ae_d    = (count_d <= AE_LVL);

    // A new error event in the clearing cycle wins over err_clr.
    ovf_d   = (ovf_q & ~err_clr) | (push & full_q);
    unf_d   = (unf_q & ~err_clr) | (pop & empty_q);
  end

  // Read stage. In FWFT mode the output register is loaded with whatever
  // will be the head after this edge. The only time that head is being
  // written on the same edge is a write that leaves exactly one word, so
  // that word is forwarded from wr_data.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (FWFT != 0) begin
      rd_valid_d = ~empty_d;
      if (!empty_d) begin
        rd_data_d = (wr_ok && (wr_addr == rd_addr_d)) ? wr_data : mem[rd_addr_d];
      end
    end else begin
      rd_valid_d = rd_ok;
      if (rd_ok) rd_data_d = mem[rd_addr];
    end
  end

  // NOTE: the storage array has no reset; clearing it would prevent RAM
  // inference, and stale words are unreachable once the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
//
// Four instances of fifo_sync_param in different configurations:
//   u_a  ADDR_W=3, strobes, standard read (scoreboard + queue model)
//   u_b  ADDR_W=3, edge mode, standard read
//   u_c  ADDR_W=3, strobes, FWFT read
//   u_d  ADDR_W=4, strobes, standard read, AF=12, AE=2
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance A ----------------
  logic       a_rst, a_wr_en, a_rd_en, a_err_clr;
  logic [3:0] a_wr_data, a_rd_data, a_count;
  logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;

  fifo_sync_param #(.DATA_W(4), .ADDR_W(3), .EDGE_MODE(0), .FWFT(0)) u_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
    .err_clr(a_err_clr), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf));

  // ---------------- instance B ----------------
  logic       b_rst, b_wr_en, b_rd_en, b_err_clr;
  logic [3:0] b_wr_data, b_rd_data, b_count;
  logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

  fifo_sync_param #(.DATA_W(4), .ADDR_W(3), .EDGE_MODE(1), .FWFT(0)) u_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
    .err_clr(b_err_clr), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf));

  // ---------------- instance C ----------------
  logic       c_rst, c_wr_en, c_rd_en, c_err_clr;
  logic [3:0] c_wr_data, c_rd_data, c_count;
  logic       c_rd_valid, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;

  fifo_sync_param #(.DATA_W(4), .ADDR_W(3), .EDGE_MODE(0), .FWFT(1)) u_c (
    .clk(clk), .rst(c_rst), .wr_en(c_wr_en), .wr_data(c_wr_data), .rd_en(c_rd_en),
    .err_clr(c_err_clr), .rd_data(c_rd_data), .rd_valid(c_rd_valid), .full(c_full),
    .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae), .count(c_count),
    .overflow(c_ovf), .underflow(c_unf));

  // ---------------- instance D ----------------
  logic       d_rst, d_wr_en, d_rd_en, d_err_clr;
  logic [3:0] d_wr_data, d_rd_data;
  logic [4:0] d_count;
  logic       d_rd_valid, d_full, d_empty, d_af, d_ae, d_ovf, d_unf;

  fifo_sync_param #(.DATA_W(4), .ADDR_W(4), .EDGE_MODE(0), .FWFT(0),
                    .AF_THRESH(12), .AE_THRESH(2)) u_d (
    .clk(clk), .rst(d_rst), .wr_en(d_wr_en), .wr_data(d_wr_data), .rd_en(d_rd_en),
    .err_clr(d_err_clr), .rd_data(d_rd_data), .rd_valid(d_rd_valid), .full(d_full),
    .empty(d_empty), .almost_full(d_af), .almost_empty(d_ae), .count(d_count),
    .overflow(d_ovf), .underflow(d_unf));

  // ---------------- reference models ----------------
  logic [3:0] a_model[$];
  logic [3:0] a_exp_q[$];   // scoreboard: words A must present on rd_data
  bit         a_ovf_m, a_unf_m;

  logic [3:0] c_model[$];
  bit         c_ovf_m, c_unf_m;

  logic [3:0] d_model[$];
  bit         d_ovf_m, d_unf_m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Level flags follow directly from the number of stored words.
  task automatic chk_state(input string p, input int n, input int depth, input int af_t,
                           input int ae_t, input logic [31:0] cnt, input logic f,
                           input logic e, input logic af, input logic ae);
    check({p, "_count"}, cnt, n);
    check({p, "_full"}, f, n == depth);
    check({p, "_empty"}, e, n == 0);
    check({p, "_almost_full"}, af, n >= af_t);
    check({p, "_almost_empty"}, ae, n <= ae_t);
  endtask

  // One cycle on A: model the request, issue it, check state after the edge.
  task automatic a_op(input bit push, input bit pop, input bit clr, input logic [3:0] d);
    int n;
    bit push_ok, pop_ok;
    n       = a_model.size();
    push_ok = push && (n < 8);
    pop_ok  = pop && (n > 0);
    a_ovf_m = (a_ovf_m && !clr) || (push && n == 8);
    a_unf_m = (a_unf_m && !clr) || (pop && n == 0);
    if (pop_ok) a_exp_q.push_back(a_model.pop_front());
    if (push_ok) a_model.push_back(d);
    a_wr_en = push; a_rd_en = pop; a_err_clr = clr; a_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_err_clr = 1'b0;
    chk_state("a", a_model.size(), 8, 4, 4, a_count, a_full, a_empty, a_af, a_ae);
    check("a_overflow", a_ovf, a_ovf_m);
    check("a_underflow", a_unf, a_unf_m);
    check("a_rd_valid_pulse", a_rd_valid, pop_ok);
  endtask

  // Scoreboard monitor for A: every rd_valid must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (a_rd_valid === 1'b1) begin
        if (a_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_spurious_rd_valid: rd_data=%0h with no word expected", a_rd_data);
        end else begin
          check("a_rd_data", a_rd_data, a_exp_q.pop_front());
        end
      end
    end
  end

  // One cycle on C (FWFT): the head of the model must sit on rd_data.
  task automatic c_op(input bit push, input bit pop, input logic [3:0] d);
    int n;
    n       = c_model.size();
    c_ovf_m = c_ovf_m || (push && n == 8);
    c_unf_m = c_unf_m || (pop && n == 0);
    if (pop && n > 0) void'(c_model.pop_front());
    if (push && n < 8) c_model.push_back(d);
    c_wr_en = push; c_rd_en = pop; c_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    c_wr_en = 1'b0; c_rd_en = 1'b0;
    chk_state("c", c_model.size(), 8, 4, 4, c_count, c_full, c_empty, c_af, c_ae);
    check("c_rd_valid", c_rd_valid, c_model.size() > 0);
    if (c_model.size() > 0) check("c_head", c_rd_data, c_model[0]);
    check("c_overflow", c_ovf, c_ovf_m);
    check("c_underflow", c_unf, c_unf_m);
  endtask

  // One cycle on D.
  task automatic d_op(input bit push, input bit pop, input logic [3:0] d);
    int n;
    bit pop_ok;
    logic [3:0] exp_word;
    n        = d_model.size();
    pop_ok   = pop && n > 0;
    exp_word = '0;
    d_ovf_m  = d_ovf_m || (push && n == 16);
    d_unf_m  = d_unf_m || (pop && n == 0);
    if (pop_ok) exp_word = d_model.pop_front();
    if (push && n < 16) d_model.push_back(d);
    d_wr_en = push; d_rd_en = pop; d_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    d_wr_en = 1'b0; d_rd_en = 1'b0;
    chk_state("d", d_model.size(), 16, 12, 2, d_count, d_full, d_empty, d_af, d_ae);
    check("d_rd_valid", d_rd_valid, pop_ok);
    if (pop_ok) check("d_rd_data", d_rd_data, exp_word);
    check("d_overflow", d_ovf, d_ovf_m);
    check("d_underflow", d_unf, d_unf_m);
  endtask

  // Pulse rd_en on B and wait (bounded) for the resulting read.
  task automatic b_pop_expect(input logic [3:0] exp, input string nm);
    bit seen;
    seen    = 1'b0;
    b_rd_en = 1'b1;
    @(negedge clk);
    b_rd_en = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (b_rd_valid === 1'b1) begin
        seen = 1'b1;
        check(nm, b_rd_data, exp);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: rd_valid not seen within 10 cycles", nm);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    {a_wr_en, a_rd_en, a_err_clr, a_wr_data} = '0;
    {b_wr_en, b_rd_en, b_err_clr, b_wr_data} = '0;
    {c_wr_en, c_rd_en, c_err_clr, c_wr_data} = '0;
    {d_wr_en, d_rd_en, d_err_clr, d_wr_data} = '0;
    {a_rst, b_rst, c_rst, d_rst} = 4'hF;
    repeat (3) @(negedge clk);
    {a_rst, b_rst, c_rst, d_rst} = 4'h0;

    // ---- reset state ----
    chk_state("a_reset", 0, 8, 4, 4, a_count, a_full, a_empty, a_af, a_ae);
    check("a_reset_rd_valid", a_rd_valid, 0);
    check("a_reset_rd_data", a_rd_data, 0);
    check("a_reset_overflow", a_ovf, 0);
    check("a_reset_underflow", a_unf, 0);

    // ---- A: fill to capacity, overflow, drain, underflow ----
    for (int i = 1; i <= 8; i++) a_op(1'b1, 1'b0, 1'b0, 4'(i));
    check("a_full_after_8", a_full, 1);
    check("a_count_after_8", a_count, 8);
    a_op(1'b1, 1'b0, 1'b0, 4'h9);
    check("a_overflow_on_9th", a_ovf, 1);
    check("a_count_stays_8", a_count, 8);
    repeat (8) a_op(1'b0, 1'b1, 1'b0, 4'h0);
    check("a_empty_after_drain", a_empty, 1);
    a_op(1'b0, 1'b1, 1'b0, 4'h0);
    check("a_underflow_on_empty_pop", a_unf, 1);
    a_op(1'b0, 1'b0, 1'b1, 4'h0);
    check("a_err_clr_overflow", a_ovf, 0);
    check("a_err_clr_underflow", a_unf, 0);

    // err_clr in the same cycle as a new overflow keeps the flag set
    for (int i = 0; i < 8; i++) a_op(1'b1, 1'b0, 1'b0, 4'(i + 3));
    a_op(1'b1, 1'b0, 1'b1, 4'hF);
    check("a_clr_vs_new_overflow", a_ovf, 1);
    a_op(1'b0, 1'b0, 1'b1, 4'h0);

    // ---- A: wrap-around with simultaneous push/pop at count 4 ----
    repeat (4) a_op(1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 20; i++) a_op(1'b1, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
    check("a_count_held_4", a_count, 4);
    repeat (4) a_op(1'b0, 1'b1, 1'b0, 4'h0);
    a_op(1'b1, 1'b1, 1'b0, 4'h3);
    check("a_pushpop_empty_count", a_count, 1);
    check("a_pushpop_empty_underflow", a_unf, 1);

    // ---- A: randomized traffic ----
    for (int i = 0; i < 300; i++) begin
      a_op($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)));
    end
    while (a_model.size() > 0) a_op(1'b0, 1'b1, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    check("a_scoreboard_drained", a_exp_q.size(), 0);

    // ---- C: FWFT ----
    c_op(1'b1, 1'b0, 4'h5);
    check("c_fwft_first_valid", c_rd_valid, 1);
    check("c_fwft_first_data", c_rd_data, 4'h5);
    c_op(1'b1, 1'b0, 4'h6);
    c_op(1'b0, 1'b1, 4'h0);
    check("c_fwft_next_data", c_rd_data, 4'h6);
    c_op(1'b0, 1'b1, 4'h0);
    check("c_fwft_valid_drops", c_rd_valid, 0);
    check("c_fwft_empty", c_empty, 1);
    for (int i = 0; i < 300; i++) begin
      c_op($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 4'($urandom_range(0, 15)));
    end

    // ---- D: thresholds and mid-operation reset ----
    d_op(1'b0, 1'b1, 4'h0);
    for (int i = 1; i <= 13; i++) begin
      d_op(1'b1, 1'b0, 4'(i));
      if (i == 2)  check("d_ae_at_2", d_ae, 1);
      if (i == 3)  check("d_ae_falls_at_3", d_ae, 0);
      if (i == 11) check("d_af_at_11", d_af, 0);
      if (i == 12) check("d_af_rises_at_12", d_af, 1);
    end
    d_op(1'b0, 1'b1, 4'h0);
    check("d_count_before_reset", d_count, 12);
    d_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_rst = 1'b0;
    d_model.delete();
    d_ovf_m = 1'b0;
    d_unf_m = 1'b0;
    chk_state("d_reset", 0, 16, 12, 2, d_count, d_full, d_empty, d_af, d_ae);
    check("d_reset_rd_data", d_rd_data, 0);
    check("d_reset_rd_valid", d_rd_valid, 0);
    check("d_reset_underflow", d_unf, 0);
    check("d_reset_overflow", d_ovf, 0);
    d_op(1'b1, 1'b0, 4'h7);
    d_op(1'b0, 1'b1, 4'h0);

    // ---- B: edge mode ----
    // wr_en rises just after edge N; first sampled at N+1, push acts at N+3.
    b_wr_data = 4'hA;
    b_wr_en   = 1'b1;
    repeat (2) @(negedge clk);
    check("b_count_edge_n2", b_count, 0);
    @(negedge clk);
    check("b_count_edge_n3", b_count, 1);
    repeat (7) @(negedge clk);
    check("b_one_push_for_level", b_count, 1);
    b_wr_en = 1'b0;
    b_pop_expect(4'hA, "b_rd_data_edge");
    repeat (2) @(negedge clk);
    check("b_empty_after_pop", b_empty, 1);
    check("b_no_underflow", b_unf, 0);

    // enable held high through a reset release
    b_wr_data = 4'hB;
    b_wr_en   = 1'b1;
    b_rst     = 1'b1;
    repeat (3) @(negedge clk);
    check("b_reset_count", b_count, 0);
    b_rst = 1'b0;
    repeat (12) @(negedge clk);
    check("b_one_push_after_reset", b_count, 1);
    b_wr_en = 1'b0;
    b_pop_expect(4'hB, "b_rd_data_after_reset");
    repeat (2) @(negedge clk);
    check("b_count_after_reset_pop", b_count, 0);
    check("b_no_overflow", b_ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the 4-bit x 512 FIFO.
- Adds:
  - configurable data width and depth
  - selectable input mode: raw strobes, or synchronised rising-edge pulses for slow/board-level enables
  - selectable read mode: standard or first-word-fall-through (FWFT)
  - fill count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags
- Sits between board-level or fabric producers/consumers in the FPGA top levels.

Parameters:
- DATA_W, 4, data word width in bits.
- ADDR_W, 9, log2 of depth; DEPTH = 2**ADDR_W; legal 2..12.
- EDGE_MODE, 1:
  - 1: wr_en/rd_en pass through 2-flop synchroniser plus rising-edge detect.
  - 0: wr_en/rd_en are used directly as per-cycle strobes.
- FWFT, 0:
  - 0: standard registered read.
  - 1: first-word-fall-through.
- AF_THRESH, DEPTH-4, almost_full asserted when count >= AF_THRESH; legal 1..DEPTH.
- AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH; legal 0..DEPTH-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request (level or strobe per EDGE_MODE).
- wr_data  in  DATA_W  write data, sampled on the cycle the internal push strobe is high.
- rd_en  in  1  read request / pop (per EDGE_MODE).
- err_clr  in  1  clears overflow and underflow.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  FWFT=0: one-cycle pulse marking new rd_data. FWFT=1: head word present.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_W+1  words stored, 0..DEPTH.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - synchroniser/edge registers = 0.
  - Memory contents are not cleared. Mid-operation reset discards all stored words; the next cycle behaves as a fresh FIFO.
- Internal strobes, push and pop:
  - EDGE_MODE=1: push = sync[1] & ~sync_d. An enable rising at edge N yields a push high in cycle N+2, acting at edge N+3. A level held high produces exactly one push. Since sync registers reset to 0, an enable held high through reset gives one push after release.
  - EDGE_MODE=0: push = wr_en and pop = rd_en in the same cycle.
- Pointers: ADDR_W+1 bits. Address = low ADDR_W bits; the MSB is the wrap bit. Pointers wrap naturally at 2*DEPTH.
- Accept rules use the registered flags of the current cycle:
  - Write accepted iff push & ~full.
  - Read accepted iff pop & ~empty.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: pop accepted, push rejected (overflow set).
  - Empty: push accepted, pop rejected (underflow set).
- Flags and count are registered, computed from next-pointer values at the same edge as the accept, so they are correct one edge after the operation:
  - count = wr_ptr_next - rd_ptr_next
  - empty = (count_next == 0)
  - full = address bits equal and wrap bits differ
- Standard read (FWFT=0):
  - On an accepted read: rd_data <= mem[rd_addr] and rd_valid = 1 for one cycle.
  - Otherwise rd_data holds its value and rd_valid = 0.
- FWFT read (FWFT=1):
  - rd_valid = ~empty. While rd_valid = 1, rd_data = oldest word.
  - An accepted pop presents the next word, or drops rd_valid if that was the last word, one edge later.
  - A write into an empty FIFO makes rd_valid = 1 with that word one edge after the write edge.
  - rd_data must be a registered output stage, not an asynchronous RAM read.
- Error flags:
  - overflow set on push & full; underflow set on pop & empty.
  - Both cleared by err_clr. A new error event in the same cycle as err_clr wins (flag stays 1).
  - Rejected operations never modify pointers or memory.

Test Plan:
- Fill to capacity (ADDR_W=3, EDGE_MODE=0, FWFT=0): push 0x1..0x8 on consecutive cycles, then pop 8 times:
  - full=1 and count=8 after the 8th edge.
  - rd_data sequence 0x1..0x8, each with a 1-cycle rd_valid.
  - empty=1 after the last pop.
- Overflow/underflow (ADDR_W=3, EDGE_MODE=0):
  - 9th push while full: overflow=1, count stays 8, word 9 never read.
  - Pop on empty: underflow=1.
  - err_clr pulse clears both; err_clr together with a new overflow leaves overflow=1.
- Wrap-around and simultaneous ops (ADDR_W=3, EDGE_MODE=0): hold count=4, push+pop every cycle for 20 cycles:
  - count stays 4, data in order, no flag glitches.
  - push+pop when empty: word stored, count=1, underflow=1.
- Edge mode (EDGE_MODE=1):
  - wr_en held high for 10 cycles with wr_data=0xA: exactly one word stored; count becomes 1 at edge N+3.
  - wr_en held high through a reset release: exactly one push after release.
- FWFT (FWFT=1, EDGE_MODE=0):
  - Push 0x5 into an empty FIFO: rd_valid=1 and rd_data=0x5 one edge later.
  - Push 0x6, then pop: rd_data=0x6.
  - Pop again: rd_valid=0, empty=1.
- Thresholds and reset (ADDR_W=4, AF_THRESH=12, AE_THRESH=2):
  - almost_empty falls at count=3; almost_full rises at count=12.
  - rst asserted at count=12: all outputs return to reset values on the next edge.
